column_shift_checker: RTL and testbench

//  Parametrised stimulus/check harness for an N x N partial-product compressor.

---
 rtl/column_shift_checker.sv | 123 ++++++++++++
 tb/tb_column_shift_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_shift_checker.sv
// Stimulus/check harness for an N x N partial-product compressor: triangular column
// shift registers feed the compressor, and its result is checked against a weighted popcount.
module column_shift_checker #(
  parameter int N    = 15,
  parameter int LAT  = 0,
  parameter int ERRW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en,
  input  logic                 clear,
  input  logic [2*N-2:0]       src_i,
  output logic [N*N-1:0]       cols_o,
  output logic                 full,
  input  logic [2*N-1:0]       res_i,
  output logic [2*N-1:0]       res_o,
  output logic                 res_valid,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic [ERRW-1:0]      err_cnt
);

  localparam int NCOL  = 2*N - 1;
  localparam int NBITS = N*N;
  localparam int OUTW  = 2*N;
  localparam int FW    = $clog2(N+1);
  localparam int CW    = $clog2(N+1);

  function automatic int col_h(input int i);
    return (i + 1 < 2*N - 1 - i) ? i + 1 : 2*N - 1 - i;
  endfunction

  function automatic int col_off(input int i);
    int s;
    s = 0;
    for (int k = 0; k < i; k++) s += col_h(k);
    return s;
  endfunction

  logic [NBITS-1:0] cols_q;
  logic [NBITS-1:0] cols_shifted;
  logic [CW-1:0]    colcnt [NCOL];
  logic [OUTW-1:0]  gold_next;
  logic [FW-1:0]    fill;
  logic [LAT:0]     tok_q;
  logic [OUTW-1:0]  gold_q [LAT+1];
  logic             issue;
  logic             capture;
  logic             bad;

  // Each column shifts towards its MSB; the popcount is taken on the post-shift contents
  // so the golden value can travel alongside the token from the shift edge onwards.
  for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
    localparam int H = col_h(gi);
    localparam int O = col_off(gi);
    logic [CW-1:0] cnt;

    if (H == 1) begin : g_single
      assign cols_shifted[O] = src_i[gi];
    end else begin : g_multi
      assign cols_shifted[O+H-1:O] = {cols_q[O+H-2:O], src_i[gi]};
    end

    always_comb begin
      cnt = '0;
      for (int k = 0; k < H; k++) cnt = cnt + CW'(cols_shifted[O+k]);
    end

    assign colcnt[gi] = cnt;
  end

  always_comb begin
    gold_next = '0;
    for (int i = 0; i < NCOL; i++) gold_next = gold_next + (OUTW'(colcnt[i]) << i);
  end

  assign issue   = shift_en && (fill >= FW'(N-1));
  assign capture = tok_q[LAT];
  assign bad     = capture && (res_i != gold_q[LAT]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_q     <= '0;
      fill       <= '0;
      tok_q      <= '0;
      for (int k = 0; k <= LAT; k++) gold_q[k] <= '0;
      res_o      <= '0;
      res_valid  <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clear) begin
      cols_q     <= '0;
      fill       <= '0;
      tok_q      <= '0;
      for (int k = 0; k <= LAT; k++) gold_q[k] <= '0;
      res_valid  <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (shift_en) begin
        cols_q <= cols_shifted;
        if (fill != FW'(N)) fill <= fill + 1'b1;
      end
      tok_q     <= (tok_q << 1) | (LAT+1)'(issue);
      gold_q[0] <= gold_next;
      for (int k = 1; k <= LAT; k++) gold_q[k] <= gold_q[k-1];
      res_valid <= capture;
      mismatch  <= bad;
      if (capture) res_o <= res_i;
      // Counter saturates rather than wrapping so a long soak cannot hide errors.
      if (bad) begin
        err_sticky <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign cols_o = cols_q;
  assign full   = (fill == FW'(N));

endmodule

// File: tb/tb_column_shift_checker.sv
// Bench for column_shift_checker: an N=15/LAT=0 instance and an N=4/LAT=2 instance,
// driven from a history-based model of the column contents.
module tb_column_shift_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [28:0]  src15 = '0;
  logic         shift_en15 = 1'b0, clear15 = 1'b0;
  logic [224:0] cols15;
  logic         full15, res_valid15, mismatch15, err_sticky15;
  logic [29:0]  res_i15, res_o15, inj15 = '0;
  logic [15:0]  err_cnt15;
  logic [63:0]  w15;

  logic [6:0]   src4 = '0;
  logic         shift_en4 = 1'b0, clear4 = 1'b0;
  logic [15:0]  cols4;
  logic         full4, res_valid4, mismatch4, err_sticky4;
  logic [7:0]   res_i4, res_o4, inj4 = '0, r1 = '0, r2 = '0;
  logic [3:0]   err_cnt4;
  logic [63:0]  w4;

  column_shift_checker #(.N(15), .LAT(0), .ERRW(16)) dut15 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en15), .clear(clear15), .src_i(src15),
    .cols_o(cols15), .full(full15), .res_i(res_i15), .res_o(res_o15), .res_valid(res_valid15),
    .mismatch(mismatch15), .err_sticky(err_sticky15), .err_cnt(err_cnt15));

  column_shift_checker #(.N(4), .LAT(2), .ERRW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en4), .clear(clear4), .src_i(src4),
    .cols_o(cols4), .full(full4), .res_i(res_i4), .res_o(res_o4), .res_valid(res_valid4),
    .mismatch(mismatch4), .err_sticky(err_sticky4), .err_cnt(err_cnt4));

  // Weighted column popcount of a flattened triangular column vector.
  function automatic logic [63:0] weigh(input logic [224:0] c, input int n);
    logic [63:0] g;
    int off, hh, cnt;
    g = 0; off = 0;
    for (int i = 0; i < 2*n-1; i++) begin
      hh = (i + 1 < 2*n-1-i) ? i + 1 : 2*n-1-i;
      cnt = 0;
      for (int k = 0; k < hh; k++) cnt += int'(c[off+k]);
      g += 64'(cnt) << i;
      off += hh;
    end
    return g;
  endfunction

  // Compressor stand-ins: combinational for N=15, two register stages for N=4.
  assign w15 = weigh(cols15, 15);
  assign res_i15 = w15[29:0] ^ inj15;
  assign w4 = weigh({209'b0, cols4}, 4);
  always @(posedge clk) begin
    r1 <= w4[7:0];
    r2 <= r1;
  end
  assign res_i4 = r2 ^ inj4;

  logic [28:0] hist15[$];
  logic [28:0] hist4[$];
  typedef struct { int due; logic [7:0] g; } exp_t;
  exp_t expq[$];
  int cyc = 0;
  int n_checks = 0, n_pass = 0;

  // Column i bit k is the src bit of column i from the k-th most recent accepted shift.
  function automatic logic [224:0] model_cols(input int d, input int n);
    logic [28:0] q[$];
    logic [224:0] o;
    int off, hh;
    if (d == 0) q = hist15; else q = hist4;
    o = '0; off = 0;
    for (int i = 0; i < 2*n-1; i++) begin
      hh = (i + 1 < 2*n-1-i) ? i + 1 : 2*n-1-i;
      for (int k = 0; k < hh; k++) if (k < q.size()) o[off+k] = q[q.size()-1-k][i];
      off += hh;
    end
    return o;
  endfunction

  function automatic logic [63:0] model_gold(input int d, input int n);
    return weigh(model_cols(d, n), n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic shift15(input logic [28:0] s);
    src15 = s; shift_en15 = 1'b1;
    tick();
    shift_en15 = 1'b0;
    hist15.push_back(s);
    if (hist15.size() > 15) hist15.delete(0);
  endtask

  task automatic shift4(input logic [6:0] s, input bit en);
    src4 = s; shift_en4 = en;
    tick();
    shift_en4 = 1'b0;
    if (en) begin
      hist4.push_back({22'b0, s});
      if (hist4.size() > 15) hist4.delete(0);
    end
  endtask

  task automatic test_reset();
    logic [224:0] m;
    #12;
    n_checks++; if (cols15 !== '0) $display("[TB] FAIL rst_cols15: got %h want 0", cols15); else n_pass++;
    n_checks++; if (full15 !== 1'b0 || res_valid15 !== 1'b0 || mismatch15 !== 1'b0 || err_sticky15 !== 1'b0)
      $display("[TB] FAIL rst_flags15: got %b%b%b%b want 0000", full15, res_valid15, mismatch15, err_sticky15); else n_pass++;
    n_checks++; if (res_o15 !== '0 || err_cnt15 !== '0) $display("[TB] FAIL rst_res15: got %h/%h want 0/0", res_o15, err_cnt15); else n_pass++;
    n_checks++; if (cols4 !== '0 || res_o4 !== '0 || err_cnt4 !== '0) $display("[TB] FAIL rst_dut4: got %h/%h/%h want 0", cols4, res_o4, err_cnt4); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) shift15(29'($urandom));
    m = model_cols(0, 15);
    n_checks++; if (cols15 !== m) $display("[TB] FAIL pre_rst_cols: got %h want %h", cols15, m); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (cols15 !== '0) $display("[TB] FAIL async_rst_cols: got %h want 0", cols15); else n_pass++;
    hist15.delete();
    #2 rst_n = 1'b1;
    shift15(29'($urandom));
    m = model_cols(0, 15);
    n_checks++; if (cols15 !== m) $display("[TB] FAIL first_shift_cols: got %h want %h", cols15, m); else n_pass++;
  endtask

  task automatic test_fill();
    clear15 = 1'b1; tick(); clear15 = 1'b0;
    hist15.delete();
    for (int j = 1; j <= 15; j++) begin
      shift15('1);
      n_checks++; if (res_valid15 !== 1'b0) $display("[TB] FAIL fill_valid%0d: got %b want 0", j, res_valid15); else n_pass++;
      if (j >= 14) begin
        n_checks++; if (full15 !== (j == 15)) $display("[TB] FAIL fill_full%0d: got %b want %b", j, full15, j == 15); else n_pass++;
      end
    end
    tick();
    n_checks++; if (res_valid15 !== 1'b1) $display("[TB] FAIL fill_pulse: got %b want 1", res_valid15); else n_pass++;
    n_checks++; if (res_o15 !== 30'h3FFF0001) $display("[TB] FAIL fill_res: got %h want 3fff0001", res_o15); else n_pass++;
    n_checks++; if (mismatch15 !== 1'b0 || err_cnt15 !== '0) $display("[TB] FAIL fill_err: got %b/%h want 0/0", mismatch15, err_cnt15); else n_pass++;
    tick();
    n_checks++; if (res_valid15 !== 1'b0 || res_o15 !== 30'h3FFF0001) $display("[TB] FAIL fill_hold: got %b/%h want 0/3fff0001", res_valid15, res_o15); else n_pass++;
  endtask

  task automatic test_mismatch(output logic [29:0] last);
    logic [63:0] g;
    inj15 = 30'h1;
    shift15(29'($urandom));
    g = model_gold(0, 15);
    tick();
    n_checks++; if (res_valid15 !== 1'b1 || mismatch15 !== 1'b1) $display("[TB] FAIL mm_flag: got %b/%b want 1/1", res_valid15, mismatch15); else n_pass++;
    n_checks++; if (err_sticky15 !== 1'b1 || err_cnt15 !== 16'd1) $display("[TB] FAIL mm_cnt1: got %b/%0d want 1/1", err_sticky15, err_cnt15); else n_pass++;
    n_checks++; if (res_o15 !== (g[29:0] ^ 30'h1)) $display("[TB] FAIL mm_res: got %h want %h", res_o15, g[29:0] ^ 30'h1); else n_pass++;
    for (int i = 0; i < 3; i++) shift15(29'($urandom));
    g = model_gold(0, 15);
    tick();
    n_checks++; if (err_cnt15 !== 16'd4) $display("[TB] FAIL mm_cnt4: got %0d want 4", err_cnt15); else n_pass++;
    n_checks++; if (res_o15 !== (g[29:0] ^ 30'h1)) $display("[TB] FAIL mm_res4: got %h want %h", res_o15, g[29:0] ^ 30'h1); else n_pass++;
    last = g[29:0] ^ 30'h1;
    inj15 = '0;
  endtask

  task automatic test_clear(input logic [29:0] last);
    shift15(29'($urandom));
    src15 = 29'($urandom); shift_en15 = 1'b1; clear15 = 1'b1;
    tick();
    shift_en15 = 1'b0; clear15 = 1'b0;
    hist15.delete();
    n_checks++; if (cols15 !== '0 || full15 !== 1'b0) $display("[TB] FAIL clr_cols: got %h/%b want 0/0", cols15, full15); else n_pass++;
    n_checks++; if (err_cnt15 !== '0 || err_sticky15 !== 1'b0) $display("[TB] FAIL clr_err: got %0d/%b want 0/0", err_cnt15, err_sticky15); else n_pass++;
    n_checks++; if (res_valid15 !== 1'b0) $display("[TB] FAIL clr_drop: got %b want 0", res_valid15); else n_pass++;
    tick();
    n_checks++; if (res_valid15 !== 1'b0 || res_o15 !== last) $display("[TB] FAIL clr_hold: got %b/%h want 0/%h", res_valid15, res_o15, last); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [224:0] m;
    logic [63:0] g;
    bit en, issue, ev;
    for (int i = 0; i < 45; i++) begin
      en = (i < 4) || (i < 40 && $urandom_range(0, 3) != 0);
      issue = en && hist4.size() >= 3;
      shift4(7'($urandom), en);
      if (issue) begin
        g = model_gold(1, 4);
        expq.push_back('{cyc + 3, g[7:0]});
      end
      ev = expq.size() > 0 && expq[0].due == cyc;
      n_checks++; if (res_valid4 !== ev) $display("[TB] FAIL b2b_valid%0d: got %b want %b", i, res_valid4, ev); else n_pass++;
      if (ev) begin
        n_checks++; if (res_o4 !== expq[0].g || mismatch4 !== 1'b0)
          $display("[TB] FAIL b2b_res%0d: got %h/%b want %h/0", i, res_o4, mismatch4, expq[0].g); else n_pass++;
        expq.delete(0);
      end
      m = model_cols(1, 4);
      n_checks++; if (cols4 !== m[15:0] || full4 !== (hist4.size() >= 4))
        $display("[TB] FAIL b2b_cols%0d: got %h/%b want %h/%b", i, cols4, full4, m[15:0], hist4.size() >= 4); else n_pass++;
    end
    n_checks++; if (expq.size() != 0) $display("[TB] FAIL b2b_lost: got %0d pending want 0", expq.size()); else n_pass++;
  endtask

  task automatic test_saturate();
    inj4 = 8'h01;
    for (int i = 0; i < 10; i++) shift4(7'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (err_cnt4 !== 4'd10 || err_sticky4 !== 1'b1) $display("[TB] FAIL sat_mid: got %0d/%b want 10/1", err_cnt4, err_sticky4); else n_pass++;
    for (int i = 0; i < 10; i++) shift4(7'($urandom), 1'b1);
    n_checks++; if (mismatch4 !== 1'b1 || res_valid4 !== 1'b1) $display("[TB] FAIL sat_flag: got %b/%b want 1/1", mismatch4, res_valid4); else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (err_cnt4 !== 4'hF) $display("[TB] FAIL sat_hold: got %h want f", err_cnt4); else n_pass++;
    inj4 = '0;
  endtask

  initial begin
    logic [29:0] last;
    test_reset();
    test_fill();
    test_mismatch(last);
    test_clear(last);
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
